// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  // One-hot decode of a 2-bit owner index.
  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: scans last_ptr+1 .. last_ptr+4 (mod 4)
// and returns the first asserted request index.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  // First hit wins; offset 4 wraps back onto last_ptr itself (lowest priority).
  always_comb begin
    pick = last_ptr;
    any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[last_ptr + SEL_W'(k)]) begin
        any  = 1'b1;
        pick = last_ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a 4:1 single-bit mux.
// Registered one-hot grant with a one-cycle break-before-make gap between owners.
// Optional feature: define MUXARB_TIMEOUT_EN to force release of an owner that has
// held the mux for MAX_HOLD cycles while another requester is waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             s0,
  output logic             s1,
  output logic             sel_valid,
  output logic             timeout_o
);

  // Reject a hold counter too narrow to reach MAX_HOLD.
  if ((1 << CNT_W) <= MAX_HOLD) begin : g_cnt_w_check
    $error("CNT_W too small for MAX_HOLD");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] pick;
  logic             any;

`ifdef MUXARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             to_q, to_d;
  logic             force_rel;

  // Owner has used its budget and someone else is waiting.
  assign force_rel = (hold_q == CNT_W'(MAX_HOLD)) && |(req & ~gnt_q);
`endif

  rr_pick4 u_pick (
    .req      (req),
    .last_ptr (ptr_q),
    .pick     (pick),
    .any      (any)
  );

  // Next-state, grant and pointer decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUXARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = onehot4(pick);
          sel_d   = pick;
          ptr_d   = pick;
`ifdef MUXARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
`ifdef MUXARB_TIMEOUT_EN
        if (force_rel) begin
          state_d = GAP;
          gnt_d   = '0;
          to_d    = 1'b1;
        end else if (!req[sel_q]) begin
          state_d = GAP;
          gnt_d   = '0;
        end else if (hold_q != CNT_W'(MAX_HOLD)) begin
          hold_d  = hold_q + 1'b1;
        end
`else
        if (!req[sel_q]) begin
          state_d = GAP;
          gnt_d   = '0;
        end
`endif
      end
      GAP: begin
        // sel keeps its value so the mux select does not glitch during the gap.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant, select and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MUXARB_TIMEOUT_EN
  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign sel_valid = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       s0, s1, sel_valid, timeout_o;

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .sel_valid (sel_valid),
    .timeout_o (timeout_o)
  );

  // Model: who owns the mux, whether we are in the dead cycle after a release,
  // who was served last, and how many grant cycles the owner has used.
  typedef struct {
    int owner;   // -1 when nobody owns the mux
    int dead;    // 1 during the cycle following a release
    int last;
    int sel;
    int held;
    int to;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.owner = -1; s.dead = 0; s.last = 3; s.sel = 0; s.held = 0; s.to = 0;
    return s;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r);
    mstate_t n;
    logic    others;
    n = s;
    n.to = 0;
    if (s.owner >= 0) begin
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (i != s.owner && r[i]) others = 1'b1;
`ifdef MUXARB_TIMEOUT_EN
      if (s.held >= MAX_HOLD && others) begin
        n.owner = -1; n.dead = 1; n.to = 1;
      end else
`endif
      if (!r[s.owner]) begin
        n.owner = -1; n.dead = 1;
      end else begin
        n.held = (s.held < MAX_HOLD) ? s.held + 1 : MAX_HOLD;
      end
    end else if (s.dead != 0) begin
      n.dead = 0;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (n.owner < 0 && r[(s.last + k) % 4]) begin
          n.owner = (s.last + k) % 4;
          n.last  = n.owner;
          n.sel   = n.owner;
          n.held  = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(input mstate_t s);
    return (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0000;
  endfunction

  mstate_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, req);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("model_gnt", 32'(gnt), 32'(exp_gnt(m)));
    chk("model_sel", 32'({s1, s0}), 32'(m.sel));
    chk("model_sel_valid", 32'(sel_valid), 32'(m.owner >= 0));
    chk("model_timeout", 32'(timeout_o), 32'(m.to));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (timeout_o) to_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    to_cnt = 0;
  endtask

  function automatic int owner_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  int seq[$];
  int cyc;

  initial begin
    // 1: single requester, grant latency and gap behaviour
    do_reset();
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_sel_valid", 32'(sel_valid), 32'h0);
    req = 4'b0001;
    tick(1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_sel", 32'({s1, s0}), 32'h0);
    chk("t1_sel_valid", 32'(sel_valid), 32'h1);
    tick(5);
    req = 4'b0000;
    tick(1);
    chk("t1_gap_gnt", 32'(gnt), 32'h0);
    chk("t1_gap_sel_valid", 32'(sel_valid), 32'h0);
    chk("t1_gap_sel", 32'({s1, s0}), 32'h0);
    tick(2);

    // 2: all requesting, owners rotate as each drops req for one clock
    do_reset();
    req = 4'b1111;
    seq.delete();
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      while (gnt == 4'b0000 && cyc < 10) begin
        tick(1);
        cyc++;
      end
      chk("t2_grant_within_bound", 32'(gnt != 4'b0000), 32'd1);
      seq.push_back(owner_of(gnt));
      tick(2);
      req = 4'b1111 & ~gnt;
      tick(1);
      req = 4'b1111;
    end
    chk("t2_seq0", 32'(seq[0]), 32'd0);
    chk("t2_seq1", 32'(seq[1]), 32'd1);
    chk("t2_seq2", 32'(seq[2]), 32'd2);
    chk("t2_seq3", 32'(seq[3]), 32'd3);
    chk("t2_seq4", 32'(seq[4]), 32'd0);

    // 3: no preemption; requester 1 served after the gap
    do_reset();
    req = 4'b0100;
    tick(1);
    chk("t3_gnt2", 32'(gnt), 32'h4);
    req = 4'b0110;
    tick(3);
    chk("t3_no_preempt", 32'(gnt), 32'h4);
    req = 4'b0010;
    tick(1);
    chk("t3_gap_gnt", 32'(gnt), 32'h0);
    chk("t3_gap_sel_hold", 32'({s1, s0}), 32'h2);
    tick(1);
    chk("t3_idle_gnt", 32'(gnt), 32'h0);
    tick(1);
    chk("t3_gnt1", 32'(gnt), 32'h2);
    chk("t3_sel1", 32'({s1, s0}), 32'h1);

    // 4: asynchronous reset in the middle of owner 3's grant
    do_reset();
    req = 4'b1000;
    tick(3);
    chk("t4_gnt3", 32'(gnt), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_gnt", 32'(gnt), 32'h0);
    chk("t4_async_sel", 32'({s1, s0}), 32'h0);
    chk("t4_async_sel_valid", 32'(sel_valid), 32'h0);
    req = 4'b1001;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("t4_gnt0_first", 32'(gnt), 32'h1);

    // 5: owner 0 never drops while 1 waits
    do_reset();
    req = 4'b0011;
    tick(1);
    chk("t5_gnt0", 32'(gnt), 32'h1);
`ifdef MUXARB_TIMEOUT_EN
    cyc = 0;
    while (!timeout_o && cyc < 40) begin
      tick(1);
      cyc++;
    end
    chk("t5_timeout_seen", 32'(timeout_o), 32'd1);
    chk("t5_timeout_cycle", 32'(cyc), 32'(MAX_HOLD + 1));
    chk("t5_gap_gnt", 32'(gnt), 32'h0);
    tick(1);
    chk("t5_pulse_one_cycle", 32'(timeout_o), 32'd0);
    tick(1);
    chk("t5_gnt1", 32'(gnt), 32'h2);
`else
    tick(40);
    chk("t5_no_timeout", 32'(to_cnt), 32'd0);
    chk("t5_gnt0_kept", 32'(gnt), 32'h1);
`endif

    // 6: lone requester never times out
    do_reset();
    req = 4'b0001;
    tick(40);
    chk("t6_no_timeout", 32'(to_cnt), 32'd0);
    chk("t6_gnt0_kept", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
